// File: rtl/pixel_plot_receiver.sv
// Pixel plot receiver: clips incoming plot requests against the framebuffer
// bounds, converts (x, y) to a linear address and queues {address, colour}
// in a small FIFO that drains into the framebuffer write port.
module pixel_plot_receiver #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int DEPTH  = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    output logic        ready,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_we,
    input  logic        fb_grant,
    output logic [2:0]  level,
    output logic [7:0]  clip_count,
    output logic        overflow
);

    localparam int          PTR_W      = $clog2(DEPTH);
    localparam logic [8:0]  WIDTH_LIM  = 9'(WIDTH);
    localparam logic [7:0]  HEIGHT_LIM = 8'(HEIGHT);
    localparam logic [14:0] ROW_STRIDE = 15'(WIDTH);
    localparam logic [2:0]  LEVEL_FULL = 3'(DEPTH);

    // FIFO entry layout: {address[14:0], colour[2:0]}
    logic [17:0]      mem_q [DEPTH];
    logic [17:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       level_q, level_d;
    logic [7:0]       clip_q, clip_d;
    logic             ovf_q, ovf_d;

    logic        in_range;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic [14:0] pix_addr;

    // Classify the request, compute its address and decide push/pop for this cycle
    always_comb begin
        in_range = ({1'b0, x} < WIDTH_LIM) && ({1'b0, y} < HEIGHT_LIM);
        pix_addr = ({8'b0, y} * ROW_STRIDE) + {7'b0, x};
        full     = (level_q == LEVEL_FULL);
        empty    = (level_q == 3'd0);
        // A grant with nothing queued is simply ignored.
        pop      = !empty && fb_grant;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push     = plot && in_range && (!full || pop);
    end

    // Next-state for pointers, occupancy, clip counter, overflow flag and storage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        clip_d   = clip_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = {pix_addr, colour};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            level_d = level_q + 3'd1;
        end else if (pop && !push) begin
            level_d = level_q - 3'd1;
        end

        if (plot && !in_range && (clip_q != 8'hFF)) begin
            clip_d = clip_q + 8'd1;
        end
        if (plot && in_range && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Control state: cleared asynchronously so a reset kills any pending write at once
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 3'd0;
            clip_q   <= 8'd0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            clip_q   <= clip_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by level_q alone
    always_ff @(posedge CLOCK_50) begin
        mem_q <= mem_d;
    end

    // Outputs come straight from registered state
    always_comb begin
        ready      = (level_q != LEVEL_FULL);
        fb_we      = (level_q != 3'd0);
        fb_addr    = mem_q[rd_ptr_q][17:3];
        fb_data    = mem_q[rd_ptr_q][2:0];
        level      = level_q;
        clip_count = clip_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_pixel_plot_receiver.sv
// Self-checking bench for pixel_plot_receiver: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_pixel_plot_receiver;

    localparam int W = 160;
    localparam int H = 120;
    localparam int D = 4;

    logic        CLOCK_50;
    logic        reset_n;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_grant;
    logic [2:0]  level;
    logic [7:0]  clip_count;
    logic        overflow;

    pixel_plot_receiver #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .ready      (ready),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_grant   (fb_grant),
        .level      (level),
        .clip_count (clip_count),
        .overflow   (overflow)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Reference model: pending pixels as addr*8+colour, in acceptance order
    int q[$];
    int m_clip;
    bit m_ovf;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        if (obs !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(level), q.size());
        chk({tag, ".fb_we"}, 32'(fb_we), (q.size() > 0) ? 1 : 0);
        chk({tag, ".ready"}, 32'(ready), (q.size() != D) ? 1 : 0);
        chk({tag, ".clip"}, 32'(clip_count), m_clip);
        chk({tag, ".ovf"}, 32'(overflow), m_ovf ? 1 : 0);
        if (q.size() > 0) begin
            chk({tag, ".fb_addr"}, 32'(fb_addr), q[0] / 8);
            chk({tag, ".fb_data"}, 32'(fb_data), q[0] % 8);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then check after the edge
    task automatic step(input int xi, input int yi, input int ci, input int pi, input int gi, input string tag);
        bit in_r, do_pop, was_full;
        x        = 8'(xi);
        y        = 7'(yi);
        colour   = 3'(ci);
        plot     = pi[0];
        fb_grant = gi[0];
        in_r     = (xi < W) && (yi < H);
        do_pop   = (q.size() > 0) && gi[0];
        was_full = (q.size() == D);
        @(posedge CLOCK_50);
        #1;
        if (do_pop) void'(q.pop_front());
        if (pi[0] && !in_r && m_clip < 255) m_clip++;
        if (pi[0] && in_r) begin
            if (!was_full || do_pop) q.push_back((yi * W + xi) * 8 + ci);
            else m_ovf = 1'b1;
        end
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges; plots during reset are ignored
    task automatic rst_pulse(input string tag);
        #2;
        reset_n = 1'b0;
        plot    = 1'b1;
        x       = 8'd1;
        y       = 7'd1;
        #1;
        q.delete();
        m_clip = 0;
        m_ovf  = 1'b0;
        check_all({tag, ".async"});
        repeat (2) @(posedge CLOCK_50);
        #1;
        check_all({tag, ".held"});
        reset_n = 1'b1;
        plot    = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        m_clip   = 0;
        m_ovf    = 1'b0;
        reset_n  = 1'b0;
        x        = '0;
        y        = '0;
        colour   = '0;
        plot     = 1'b0;
        fb_grant = 1'b0;
        #3;
        check_all("reset");
        @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;

        // Single pixel: visible one cycle after acceptance, gone after the grant
        step(5, 2, 2, 1, 1, "single");
        chk("single.addr325", 32'(fb_addr), 325);
        chk("single.data", 32'(fb_data), 2);
        step(0, 0, 0, 0, 1, "single_drain");
        chk("single.we_off", 32'(fb_we), 0);

        // Corner pixel and clipping on both axes
        step(159, 119, 7, 1, 0, "corner");
        chk("corner.addr", 32'(fb_addr), 19199);
        step(160, 0, 1, 1, 1, "clip_x");
        step(0, 120, 1, 1, 1, "clip_y");
        chk("clip.count2", 32'(clip_count), 2);
        chk("clip.level0", 32'(level), 0);

        // Five plots with no grant: four kept, fifth dropped, then drained in order
        for (int i = 0; i < 5; i++) step(10 + i, 3 + i, i, 1, 0, "fill");
        chk("fill.level4", 32'(level), 4);
        chk("fill.ready0", 32'(ready), 0);
        chk("fill.ovf1", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            chk("drain.order", 32'(fb_addr), (3 + i) * W + 10 + i);
            step(0, 0, 0, 0, 1, "drain");
        end

        // Full FIFO with simultaneous plot and grant: accepted, no overflow
        rst_pulse("rst_a");
        for (int i = 0; i < 4; i++) step(20 + i, 50, 3, 1, 0, "fill2");
        step(99, 99, 5, 1, 1, "push_pop_full");
        chk("push_pop_full.level", 32'(level), 4);
        chk("push_pop_full.ovf0", 32'(overflow), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, "drain2");

        // Clip counter saturates
        for (int i = 0; i < 300; i++) step(200, 5, 0, 1, $urandom_range(0, 1), "clip_sat");
        chk("clip_sat.255", 32'(clip_count), 255);

        // Reset with three pending pixels discards them
        for (int i = 0; i < 3; i++) step(1 + i, 1, 6, 1, 0, "pre_rst");
        chk("pre_rst.level3", 32'(level), 3);
        rst_pulse("rst_b");
        chk("rst_b.we0", 32'(fb_we), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, "post_rst");

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7),
                 ($urandom_range(0, 9) < 6) ? 1 : 0, $urandom_range(0, 1), "rand");
            if (i == 1000) rst_pulse("rst_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_plot_receiver.md
PIXEL_PLOT_RECEIVER -- requirements
Module: pixel_plot_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 160, meaning framebuffer columns.
REQ-002 SHALL have parameter HEIGHT, default 120, meaning framebuffer rows.
REQ-003 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two).
REQ-004 SHALL have port CLOCK_50  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port x  input  8  plot column.
REQ-007 SHALL have port y  input  7  plot row.
REQ-008 SHALL have port colour  input  3  plot colour {R,G,B}.
REQ-009 SHALL have port plot  input  1  plot request strobe, one pixel per high cycle.
REQ-010 SHALL have port ready  output  1  high when FIFO not full.
REQ-011 SHALL have port fb_addr  output  15  framebuffer write address of FIFO head.
REQ-012 SHALL have port fb_data  output  3  colour of FIFO head.
REQ-013 SHALL have port fb_we  output  1  write request, high when FIFO not empty.
REQ-014 SHALL have port fb_grant  input  1  framebuffer accepts the write this cycle.
REQ-015 SHALL have port level  output  3  current FIFO occupancy, 0..DEPTH.
REQ-016 SHALL have port clip_count  output  8  saturating count of out-of-range plots.
REQ-017 SHALL have port overflow  output  1  sticky flag, in-range plot dropped while full.

Function
REQ-018 SHALL classify a plot=1 cycle as clipped when x >= WIDTH or y >= HEIGHT.
REQ-019 SHALL on a clipped plot not enqueue, and increment clip_count, holding at 255.
REQ-020 SHALL compute address = y*WIDTH + x, 15 bits, no truncation for in-range inputs.
REQ-021 SHALL enqueue {address, colour} on an in-range plot when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-022 SHALL on an in-range plot with FIFO full and no same-cycle pop drop the pixel, set overflow, and leave FIFO contents unchanged.
REQ-023 SHALL pop the head when fb_we=1 and fb_grant=1 at a rising edge.
REQ-024 SHALL drive fb_addr and fb_data from the registered head entry; values when fb_we=0 are don't-care.
REQ-025 SHALL make the first accepted pixel visible on fb_we exactly one cycle after acceptance (empty FIFO case).
REQ-026 SHALL preserve plot order: pixels reach fb_addr/fb_data in acceptance order, no duplication.
REQ-027 SHALL on simultaneous push and pop leave level unchanged.
REQ-028 SHALL update level as +1 on push only, -1 on pop only, never exceeding DEPTH or going below 0.
REQ-029 SHALL derive ready = (level != DEPTH) combinationally from registered state only (no dependence on plot or fb_grant).
REQ-030 SHALL ignore fb_grant when the FIFO is empty.
REQ-031 SHALL wrap read and write pointers modulo DEPTH.

Reset
REQ-032 SHALL on reset_n=0, asynchronously: level=0, fb_we=0, ready=1, clip_count=0, overflow=0, pointers=0.
REQ-033 SHALL on reset mid-operation discard all queued pixels; no write issued after reset assertion.
REQ-034 SHALL clear overflow and clip_count only by reset.
REQ-035 SHALL ignore plot during reset and accept plots from the first rising edge after reset_n deasserts.

Verification
REQ-036 SHALL cover: plot (x=5,y=2,colour=3'b010), fb_grant=1 -> next cycle fb_we=1, fb_addr=325, fb_data=3'b010; following cycle fb_we=0.
REQ-037 SHALL cover: plot (x=159,y=119) -> fb_addr=19199; plot (x=160,y=0) and (x=0,y=120) -> nothing enqueued, clip_count=2.
REQ-038 SHALL cover: fb_grant=0, 5 consecutive in-range plots -> level=4, ready=0, overflow=1, first 4 pixels drained in order after fb_grant=1.
REQ-039 SHALL cover: FIFO full, plot and fb_grant both high same cycle -> pixel accepted, level stays 4, overflow stays 0.
REQ-040 SHALL cover: 300 clipped plots -> clip_count=255.
REQ-041 SHALL cover: reset_n pulsed low with level=3 -> fb_we=0, level=0 immediately, no further fb writes.
